// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared ALU opcode and entry-sequencer types
package cpu_types_pkg;
  typedef enum logic [3:0] {
    ALU_AND = 4'h0,
    ALU_OR  = 4'h1,
    ALU_ADD = 4'h2,
    ALU_SUB = 4'h6,
    ALU_SLT = 4'h7,
    ALU_NOR = 4'hC
  } aluop_t;
  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    ENTER_B  = 3'd1,
    ENTER_OP = 3'd2,
    EXEC     = 3'd3,
    SHOW     = 3'd4
  } entry_state_t;
  function automatic logic [31:0] sext_operand(input logic [16:0] s);
    return {{16{s[16]}}, s[15:0]};
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronize and debounce one active-low key, pulse on press
module key_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic stable;
  logic differ;
  logic flip;
  assign differ = sync[SYNC_STAGES-1] != stable;
  assign flip = differ && cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '1;
      cnt <= '0;
      stable <= 1'b1;
      press <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key_n};
      cnt <= (differ && !flip) ? cnt + 1'b1 : '0;
      stable <= flip ? ~stable : stable;
      press <= flip && stable;
    end
  end
endmodule

// File: rtl/alu_entry_ctrl.sv
// alu_entry_ctrl: debounced A/B/opcode entry sequencer with ALU result capture
module alu_entry_ctrl
  import cpu_types_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  key_n,
  input  logic [16:0] sw,
  input  logic [31:0] alu_o_in,
  input  logic [2:0]  alu_nvz_in,
  output aluop_t      alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] result,
  output logic [2:0]  flags,
  output logic [1:0]  stage,
  output logic        done
);
  logic [3:0] press;
  logic unused_key2;
  entry_state_t state;
  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk(CLK),
      .rst(RST),
      .key_n(key_n[k]),
      .press(press[k])
    );
  end
  assign unused_key2 = press[2];
  always_comb begin
    stage = state == SHOW ? 2'd3 :
            (state == ENTER_OP || state == EXEC) ? 2'd2 :
            state == ENTER_B ? 2'd1 : 2'd0;
  end
  always_ff @(posedge CLK) begin
    if (RST || press[3]) begin
      state <= ENTER_A;
      alu_op <= aluop_t'(4'h0);
      alu_a <= '0;
      alu_b <= '0;
      result <= '0;
      flags <= '0;
      done <= 1'b0;
    end else begin
      case (state)
        ENTER_A: if (press[0]) begin
          alu_a <= sext_operand(sw);
          state <= ENTER_B;
        end
        ENTER_B: if (press[0]) begin
          alu_b <= sext_operand(sw);
          state <= ENTER_OP;
        end else if (press[1]) state <= ENTER_A;
        ENTER_OP: if (press[0]) begin
          alu_op <= aluop_t'(sw[3:0]);
          state <= EXEC;
        end else if (press[1]) state <= ENTER_B;
        EXEC: begin
          result <= alu_o_in;
          flags <= alu_nvz_in;
          done <= 1'b1;
          state <= SHOW;
        end
        SHOW: if (press[0]) begin
          done <= 1'b0;
          state <= ENTER_A;
        end else if (press[1]) begin
          done <= 1'b0;
          state <= ENTER_OP;
        end
        default: state <= ENTER_A;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_entry_ctrl.sv
// tb_alu_entry_ctrl: directed self-checking bench for the ALU entry sequencer
module tb_alu_entry_ctrl;
  import cpu_types_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] key_n;
  logic [16:0] sw;
  logic [31:0] alu_o_in;
  logic [2:0] alu_nvz_in;
  aluop_t alu_op;
  logic [31:0] alu_a, alu_b, result;
  logic [2:0] flags;
  logic [1:0] stage;
  logic done;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  alu_entry_ctrl #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .CLK(clk),
    .RST(rst),
    .key_n(key_n),
    .sw(sw),
    .alu_o_in(alu_o_in),
    .alu_nvz_in(alu_nvz_in),
    .alu_op(alu_op),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .result(result),
    .flags(flags),
    .stage(stage),
    .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input logic [3:0] mask);
    key_n = ~mask;
    cycles(10);
    key_n = 4'hF;
    cycles(10);
  endtask
  task automatic chk_cleared(input string tag);
    chk({tag, "_stage"}, 32'(stage), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_a"}, alu_a, 32'd0);
    chk({tag, "_b"}, alu_b, 32'd0);
    chk({tag, "_op"}, 32'(alu_op), 32'd0);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_flags"}, 32'(flags), 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    key_n = 4'hF;
    sw = '0;
    alu_o_in = '0;
    alu_nvz_in = '0;
    cycles(3);
    rst = 1'b0;
    cycles(1);
    chk_cleared("reset");
    cycles(100);
    chk("idle_stage", 32'(stage), 32'd0);
    key_n = 4'b1110;
    cycles(3);
    key_n = 4'hF;
    cycles(10);
    chk("glitch_stage", 32'(stage), 32'd0);
    sw = {1'b1, 16'h8000};
    press(4'b0001);
    chk("a_stage", 32'(stage), 32'd1);
    chk("a_val", alu_a, 32'hFFFF8000);
    sw = 17'h00005;
    press(4'b0001);
    chk("b_stage", 32'(stage), 32'd2);
    chk("b_val", alu_b, 32'h00000005);
    sw = 17'(ALU_ADD);
    alu_o_in = 32'hFFFF8005;
    alu_nvz_in = 3'b100;
    key_n = 4'b1110;
    cycles(7);
    chk("exec_op", 32'(alu_op), 32'(ALU_ADD));
    chk("exec_stage", 32'(stage), 32'd2);
    chk("exec_done", 32'(done), 32'd0);
    cycles(1);
    chk("cap_done", 32'(done), 32'd1);
    chk("cap_stage", 32'(stage), 32'd3);
    chk("cap_result", result, 32'hFFFF8005);
    chk("cap_flags", 32'(flags), 32'd4);
    cycles(2);
    key_n = 4'hF;
    cycles(10);
    alu_o_in = 32'h0;
    alu_nvz_in = 3'b001;
    cycles(5);
    chk("hold_result", result, 32'hFFFF8005);
    chk("hold_flags", 32'(flags), 32'd4);
    press(4'b0010);
    chk("back_stage", 32'(stage), 32'd2);
    chk("back_done", 32'(done), 32'd0);
    chk("back_a", alu_a, 32'hFFFF8000);
    chk("back_b", alu_b, 32'h00000005);
    sw = 17'(ALU_SUB);
    alu_o_in = 32'hFFFF7FFB;
    alu_nvz_in = 3'b100;
    press(4'b0001);
    chk("sub_stage", 32'(stage), 32'd3);
    chk("sub_op", 32'(alu_op), 32'(ALU_SUB));
    chk("sub_result", result, 32'hFFFF7FFB);
    chk("sub_done", 32'(done), 32'd1);
    press(4'b0001);
    chk("next_stage", 32'(stage), 32'd0);
    chk("next_done", 32'(done), 32'd0);
    chk("next_a", alu_a, 32'hFFFF8000);
    chk("next_op", 32'(alu_op), 32'(ALU_SUB));
    sw = 17'h01234;
    press(4'b0001);
    chk("a2_val", alu_a, 32'h00001234);
    press(4'b0100);
    chk("key2_stage", 32'(stage), 32'd1);
    press(4'b1001);
    chk_cleared("clear");
    sw = 17'h00007;
    press(4'b0001);
    press(4'b0001);
    chk("pre_rst_stage", 32'(stage), 32'd2);
    chk("pre_rst_b", alu_b, 32'h00000007);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk_cleared("midrst");
    sw = 17'h1FFFF;
    press(4'b0001);
    chk("neg1_a", alu_a, 32'hFFFFFFFF);
    press(4'b0001);
    sw = 17'h0000F;
    press(4'b0001);
    chk("raw_op", 32'(alu_op), 32'h0000000F);
    chk("raw_stage", 32'(stage), 32'd3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_entry_ctrl.md
Name: alu_entry_ctrl

Overview:
Operand/opcode entry sequencer that sits directly upstream of the ALU on the FPGA board.
- Debounces the raw push-buttons.
- Walks the user through entering A, B and the opcode from the switches, then drives the ALU interface with stable latched values.
- Captures the ALU result and flags into a hold register for the hex/LED display stage.
- Replaces the clock-less switch-edge latching with a properly clocked, debounced flow.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable samples before a key level is accepted (5 ms at 50 MHz)
SYNC_STAGES, 2, synchronizer flops on each raw key input

Ports:
CLK  in  1  system clock
RST  in  1  reset, synchronous, active-high
key_n  in  4  raw push-buttons, active-low (KEY0 advance, KEY1 back, KEY2 unused, KEY3 clear)
sw  in  17  raw switches: sw[16] sign, sw[15:0] operand value, sw[3:0] opcode
alu_o_in  in  32  ALU result O
alu_nvz_in  in  3  ALU flags {N,V,Z}
alu_op  out  4  aluop_t presented to the ALU
alu_a  out  32  operand A
alu_b  out  32  operand B
result  out  32  captured ALU result for display
flags  out  3  captured {N,V,Z}
stage  out  2  current entry state, for LEDs
done  out  1  high while the captured result is valid

Behaviour:
Reset (RST high at a CLK edge):
- Synchronizer flops are set to 1 (released).
- Debounce counters are 0; stable levels are released.
- alu_op, alu_a, alu_b, result and flags are 0.
- done is 0; state is ENTER_A (stage=0).
- RST asserted mid-entry aborts to this same state on the next edge.

Debounce:
- Each key passes through SYNC_STAGES flops.
- If the synchronized level differs from the stable level, the counter increments; otherwise it clears.
- When the counter reaches DEBOUNCE_CYCLES-1 and the level still differs, the stable level flips and the counter clears.
- A press event is a one-cycle pulse when stable goes released->pressed. Release generates no event.
- Latency from a clean raw edge to the press pulse is SYNC_STAGES+DEBOUNCE_CYCLES cycles.
- A glitch shorter than DEBOUNCE_CYCLES produces no event.

Operand form:
- Sign-extended operand is {{16{sw[16]}}, sw[15:0]}, sampled on the cycle of the event.

FSM (stage encoding in parentheses):
- ENTER_A (0): KEY0 press -> alu_a <= operand, go to ENTER_B.
- ENTER_B (1): KEY0 press -> alu_b <= operand, go to ENTER_OP. KEY1 press -> ENTER_A.
- ENTER_OP (2): KEY0 press -> alu_op <= sw[3:0], go to EXEC. KEY1 press -> ENTER_B.
- EXEC (internal, stage=2): lasts exactly one cycle; the ALU inputs are already stable. result <= alu_o_in, flags <= alu_nvz_in, done <= 1, go to SHOW.
- SHOW (3): holds result, flags and done. KEY0 press -> done <= 0, ENTER_A; alu_a, alu_b and alu_op are retained. KEY1 press -> done <= 0, ENTER_OP, allowing an opcode change on the same operands.

Event and hold rules:
- KEY3 press in any state: alu_a, alu_b, alu_op, result and flags <= 0; done <= 0; state ENTER_A.
- Priority of simultaneous events: KEY3 > KEY0 > KEY1. KEY2 is ignored.
- Events arriving in EXEC are dropped.
- alu_a, alu_b and alu_op change only on the qualifying event. They are otherwise held, so the ALU output is stable for display.
- Result latency: captured on the edge one cycle after the KEY0 event that enters the opcode.
- Opcode values outside the defined aluop_t range are passed through unchanged; the ALU's behaviour on them is the ALU's concern.

Decomposition:
- cpu_types_pkg already supplies aluop_t; alu_op is typed aluop_t.
- Add entry_state_t (ENTER_A, ENTER_B, ENTER_OP, EXEC, SHOW) to cpu_types_pkg next to it.
- One sub-module, key_debounce: single key, synchronizer plus counter plus press pulse, parameterised by SYNC_STAGES and DEBOUNCE_CYCLES. It is instantiated four times.
- The bench overrides DEBOUNCE_CYCLES=4.

Test Plan:
- Reset hold, then release with all keys high -> all outputs 0, stage=0, done=0; no events for 100 cycles.
- KEY0 low for only 3 cycles with DEBOUNCE_CYCLES=4 -> no state change. Held low for 10 cycles -> exactly one press pulse, stage 0->1.
- sw={1,16'h8000}, press KEY0 -> alu_a=32'hFFFF8000. sw=17'h00005, press KEY0 -> alu_b=32'h00000005. sw[3:0]=ALU_ADD encoding, press KEY0 -> alu_op=ALU_ADD. With alu_o_in=32'hFFFF8005 and alu_nvz_in=3'b100: result and flags latch one cycle later, done=1, stage=3.
- In SHOW, change alu_o_in to 32'h0 -> result holds 32'hFFFF8005. Press KEY1 -> stage=2, done=0, alu_a and alu_b unchanged. New opcode plus KEY0 -> new capture.
- In ENTER_B, press KEY0 and KEY3 in the same cycle -> clear wins: stage=0, alu_a=0, alu_b unchanged at 0.
- Assert RST for one cycle while in ENTER_OP -> next edge: stage=0, all outputs 0.
